// File: rtl/pwm32_core.sv
// pwm32_core: prescaled 32-bit period timer with a PWM output and a per-period tick.
// It is driven by the PRE / TMRCMP1 / TMRCMP2 / TMREN outputs of the APB PWM32 wrapper.
//
// Build option PWM32_SHADOW_EN:
//   - Defined: the prescale, period-top and duty values are held in shadow registers.
//     They are reloaded when the timer starts and at every period wrap, so a period
//     is never glitched by a mid-period register write.
//   - Undefined (default): the register values are used live, with no shadow flops.
//
// running is a direct decode of the FSM state register and serves as its state view.
module pwm32_core #(
  parameter int CNT_W = 32
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [CNT_W-1:0] PRE,
  input  logic [CNT_W-1:0] TMRCMP1,
  input  logic [CNT_W-1:0] TMRCMP2,
  input  logic             TMREN,
  output logic             pwm_out,
  output logic             period_tick,
  output logic [CNT_W-1:0] cnt_val,
  output logic             running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic             period_tick_d;
  logic             load_cfg;

  // Effective configuration seen by the counters and the compare.
  logic [CNT_W-1:0] pre_e, top_e, duty_e;

  logic tick;
  logic wrap;

`ifdef PWM32_SHADOW_EN
  logic [CNT_W-1:0] pre_sh_q, top_sh_q, duty_sh_q;

  // Shadow copies reload on start and on every period wrap only.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pre_sh_q  <= '0;
      top_sh_q  <= '0;
      duty_sh_q <= '0;
    end else if (load_cfg) begin
      pre_sh_q  <= PRE;
      top_sh_q  <= TMRCMP1;
      duty_sh_q <= TMRCMP2;
    end
  end

  assign pre_e  = pre_sh_q;
  assign top_e  = top_sh_q;
  assign duty_e = duty_sh_q;
`else
  assign pre_e  = PRE;
  assign top_e  = TMRCMP1;
  assign duty_e = TMRCMP2;
`endif

  // A timer tick fires when the prescaler reaches pre_e.
  // If pre_e drops below psc, psc keeps counting and wraps through 2^CNT_W.
  // That wrap-through is intended behaviour.
  assign tick = (psc_q == pre_e);
  assign wrap = tick && (cnt_q == top_e);

  // Next-state and datapath decode; everything returns to zero outside RUN.
  always_comb begin
    state_d       = state_q;
    psc_d         = '0;
    cnt_d         = '0;
    pwm_d         = 1'b0;
    wrap_pend_d   = 1'b0;
    period_tick_d = 1'b0;
    load_cfg      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TMREN) begin
          state_d  = RUN;
          load_cfg = 1'b1;
        end
      end
      RUN: begin
        if (!TMREN) begin
          // Disable wins over everything: no period completion, no pending tick.
          state_d = IDLE;
        end else begin
          psc_d = tick ? '0 : psc_q + CNT_W'(1);
          if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          // Compare uses the registered count, giving a fixed one-cycle lag.
          pwm_d         = (cnt_q < duty_e);
          wrap_pend_d   = wrap;
          period_tick_d = wrap_pend_q;
          load_cfg      = wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psc_q       <= '0;
      cnt_q       <= '0;
      pwm_out     <= 1'b0;
      wrap_pend_q <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      psc_q       <= psc_d;
      cnt_q       <= cnt_d;
      pwm_out     <= pwm_d;
      wrap_pend_q <= wrap_pend_d;
      period_tick <= period_tick_d;
    end
  end

  assign cnt_val = cnt_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_pwm32_core.sv
// tb_pwm32_core: directed bench for pwm32_core with hand-derived expected waveforms.
// Inputs change and outputs are sampled 1 time unit after each rising PCLK edge.
// "k" below is the number of rising edges since the edge that entered RUN (k=0).
module tb_pwm32_core;

  localparam int CNT_W = 32;

  logic             PCLK;
  logic             PRESET;
  logic [CNT_W-1:0] PRE;
  logic [CNT_W-1:0] TMRCMP1;
  logic [CNT_W-1:0] TMRCMP2;
  logic             TMREN;
  logic             pwm_out;
  logic             period_tick;
  logic [CNT_W-1:0] cnt_val;
  logic             running;

  int total = 0;
  int bad   = 0;

  pwm32_core #(.CNT_W(CNT_W)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PRE        (PRE),
    .TMRCMP1    (TMRCMP1),
    .TMRCMP2    (TMRCMP2),
    .TMREN      (TMREN),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .cnt_val    (cnt_val),
    .running    (running)
  );

  // Clock and reset block
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Driver tasks
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic go_idle();
    PRESET = 1'b0;
    TMREN  = 1'b0;
    step();
    step();
  endtask

  // Configure, raise TMREN, and advance through the edge that enters RUN (k=0).
  task automatic start(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] t,
                       input logic [CNT_W-1:0] d);
    PRE     = p;
    TMRCMP1 = t;
    TMRCMP2 = d;
    TMREN   = 1'b1;
    step();
  endtask

  task automatic test_reset();
    PRESET  = 1'b1;
    TMREN   = 1'b1;
    PRE     = 1;
    TMRCMP1 = 3;
    TMRCMP2 = 2;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({running, pwm_out, period_tick, cnt_val} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got run=%0b pwm=%0b tick=%0b cnt=%0d want all 0",
                 i, running, pwm_out, period_tick, cnt_val);
      end
    end
    PRESET = 1'b0;
    step();
    total++;
    if (running !== 1'b1 || cnt_val !== 0 || pwm_out !== 1'b0 || period_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got run=%0b cnt=%0d pwm=%0b tick=%0b want run=1 cnt=0 pwm=0 tick=0",
               running, cnt_val, pwm_out, period_tick);
    end
  endtask

  // PRE=1, TOP=3, DUTY=2: period 8 edges, high 4 / low 4.
  // For k>=1: cnt=(k%8)/2, pwm=((k-1)%8)<4, and period_tick fires at k=9,17,...
  task automatic test_basic();
    logic [CNT_W-1:0] e_cnt;
    logic             e_pwm;
    logic             e_tick;
    go_idle();
    start(1, 3, 2);
    total++;
    if (running !== 1'b1 || pwm_out !== 1'b0 || cnt_val !== 0) begin
      bad++;
      $display("FAIL basic_start got run=%0b pwm=%0b cnt=%0d want run=1 pwm=0 cnt=0",
               running, pwm_out, cnt_val);
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      e_cnt  = CNT_W'((k % 8) / 2);
      e_pwm  = (((k - 1) % 8) < 4);
      e_tick = (k >= 9) && (((k - 1) % 8) == 0);
      total++;
      if (cnt_val !== e_cnt || pwm_out !== e_pwm || period_tick !== e_tick || running !== 1'b1) begin
        bad++;
        $display("FAIL basic_wave k=%0d got cnt=%0d pwm=%0b tick=%0b run=%0b want cnt=%0d pwm=%0b tick=%0b run=1",
                 k, cnt_val, pwm_out, period_tick, running, e_cnt, e_pwm, e_tick);
      end
    end
  endtask

  // All-zero config wraps every tick; period_tick is high from k=2 on. Then duty 5 > top 0.
  task automatic test_extremes();
    go_idle();
    start(0, 0, 0);
    for (int k = 2; k <= 6; k++) begin
      if (k == 2) step();
      step();
      total++;
      if (pwm_out !== 1'b0 || period_tick !== 1'b1 || cnt_val !== 0) begin
        bad++;
        $display("FAIL extreme_zero k=%0d got pwm=%0b tick=%0b cnt=%0d want pwm=0 tick=1 cnt=0",
                 k, pwm_out, period_tick, cnt_val);
      end
    end
    TMRCMP2 = 5;
    step();
    for (int k = 8; k <= 12; k++) begin
      step();
      total++;
      if (pwm_out !== 1'b1 || period_tick !== 1'b1) begin
        bad++;
        $display("FAIL extreme_full k=%0d got pwm=%0b tick=%0b want pwm=1 tick=1",
                 k, pwm_out, period_tick);
      end
    end
  endtask

  // Drop TMREN when cnt_val=2 (k=4); the next edge returns everything to zero.
  task automatic test_disable_mid();
    go_idle();
    start(1, 3, 2);
    repeat (4) step();
    total++;
    if (cnt_val !== 2) begin
      bad++;
      $display("FAIL disable_pre_cnt got cnt=%0d want 2", cnt_val);
    end
    TMREN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({running, pwm_out, period_tick, cnt_val} !== '0) begin
        bad++;
        $display("FAIL disable_mid cyc=%0d got run=%0b pwm=%0b tick=%0b cnt=%0d want all 0",
                 i, running, pwm_out, period_tick, cnt_val);
      end
    end
  endtask

  // TMREN drops at k=7 (cnt=3, prescaler at 1); edge 8 would have been the wrap.
  task automatic test_drop_on_wrap();
    go_idle();
    start(1, 3, 2);
    repeat (7) step();
    total++;
    if (cnt_val !== 3) begin
      bad++;
      $display("FAIL wrapdrop_pre_cnt got cnt=%0d want 3", cnt_val);
    end
    TMREN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({running, pwm_out, period_tick, cnt_val} !== '0) begin
        bad++;
        $display("FAIL wrap_drop cyc=%0d got run=%0b pwm=%0b tick=%0b cnt=%0d want all 0",
                 i, running, pwm_out, period_tick, cnt_val);
      end
    end
  endtask

  // Raise TMRCMP2 to 4 at cnt_val=1 (k=2).
  // Shadow build: the current period keeps duty 2, then the next period is fully high.
  // Live build: pwm is high from k=3 onward.
  task automatic test_shadow_update();
    logic e_pwm;
    go_idle();
    start(1, 3, 2);
    repeat (2) step();
    TMRCMP2 = 4;
    for (int k = 3; k <= 16; k++) begin
      step();
`ifdef PWM32_SHADOW_EN
      e_pwm = (k <= 4) || (k >= 9);
`else
      e_pwm = 1'b1;
`endif
      total++;
      if (pwm_out !== e_pwm || cnt_val !== CNT_W'((k % 8) / 2)) begin
        bad++;
        $display("FAIL duty_update k=%0d got pwm=%0b cnt=%0d want pwm=%0b cnt=%0d",
                 k, pwm_out, cnt_val, e_pwm, (k % 8) / 2);
      end
    end
  endtask

  // PRESET mid-period overrides a running timer; with TMREN held, RUN resumes from zero.
  task automatic test_back_to_back();
    go_idle();
    start(1, 3, 2);
    repeat (3) step();
    PRESET = 1'b1;
    step();
    total++;
    if ({running, pwm_out, period_tick, cnt_val} !== '0) begin
      bad++;
      $display("FAIL midreset got run=%0b pwm=%0b tick=%0b cnt=%0d want all 0",
               running, pwm_out, period_tick, cnt_val);
    end
    PRESET = 1'b0;
    step();
    step();
    total++;
    if (running !== 1'b1 || pwm_out !== 1'b1 || cnt_val !== 0) begin
      bad++;
      $display("FAIL midreset_restart got run=%0b pwm=%0b cnt=%0d want run=1 pwm=1 cnt=0",
               running, pwm_out, cnt_val);
    end
  endtask

  // Test sequence and final report
  initial begin
    PRESET  = 1'b1;
    TMREN   = 1'b0;
    PRE     = '0;
    TMRCMP1 = '0;
    TMRCMP2 = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_disable_mid();
    test_drop_on_wrap();
    test_shadow_update();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm32_core.md
Name: pwm32_core

Overview:
Timer/compare engine behind the APB PWM32 register wrapper. It consumes the PRE, TMRCMP1, TMRCMP2 and TMREN register outputs. It sequences a prescaler and a 32-bit period counter, and generates a PWM waveform plus a per-period tick. It sits between the APB PWM32 wrapper and the pad/IRQ logic in the APB subsystem.

Parameters:
CNT_W, 32, width of prescaler counter, period counter, PRE, TMRCMP1 and TMRCMP2.

Ports:
PCLK  input  1  clock; all logic on rising edge.
PRESET  input  1  synchronous reset, active-high.
PRE  input  CNT_W  prescaler: one timer tick every PRE+1 PCLK cycles.
TMRCMP1  input  CNT_W  period top: counter runs 0..TMRCMP1 (period = TMRCMP1+1 ticks).
TMRCMP2  input  CNT_W  duty threshold: output high while cnt < TMRCMP2.
TMREN  input  1  enable; level-sensitive.
pwm_out  output  1  registered PWM waveform.
period_tick  output  1  one-cycle pulse per completed period.
cnt_val  output  CNT_W  current period counter value.
running  output  1  high when the FSM is in RUN.

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is synchronous and active-high. All outputs are registered.
- Reset values: pwm_out=0, period_tick=0, cnt_val=0, running=0. Prescaler counter is 0. FSM is in IDLE.
- FSM states: IDLE and RUN.
  - IDLE: counters are held at 0, pwm_out=0, period_tick=0.
  - IDLE -> RUN on the first cycle TMREN=1 is sampled. In that same edge, the effective config (pre_e, top_e, duty_e) is loaded and counters are set to 0.
  - RUN -> IDLE on the first cycle TMREN=0 is sampled. At that edge, counters clear, pwm_out goes 0 and running goes 0. There is no graceful period completion.
  - PRESET has priority over everything and can occur mid-period. It produces the reset values on the next edge.
- Prescaler (RUN only):
  - If psc==pre_e: psc<=0 and a tick is generated this cycle.
  - Else: psc<=psc+1.
  - If pre_e=0, a tick occurs every cycle.
  - If pre_e is reduced below the current psc (live mode only), psc counts up and wraps at 2^CNT_W. This is accepted behaviour and must not be "fixed".
- Period counter, on a tick:
  - If cnt==top_e: cnt<=0, and period_tick is asserted on the next cycle for exactly 1 cycle. This is the wrap event.
  - Else: cnt<=cnt+1.
  - If top_e=0, every tick is a wrap.
- pwm_out, in RUN each cycle: pwm_out <= (cnt < duty_e), using current registered cnt. This gives a fixed 1-cycle lag relative to cnt_val.
  - duty_e=0 gives a constant 0.
  - duty_e > top_e gives a constant 1 (100%).
  - Comparison is unsigned, CNT_W bits.
- The first RUN cycle has cnt=0, so pwm_out rises one cycle after running when duty_e>0.
- Simultaneous events:
  - TMREN falling in the same cycle as a wrap: TMREN wins. Next state is IDLE and period_tick=0.
  - A register write landing on a wrap cycle: the new value is captured at that wrap (shadow mode only).

Optional Feature:
Macro PWM32_SHADOW_EN.
- Defined:
  - pre_e, top_e and duty_e are internal shadow registers.
  - They are loaded from PRE/TMRCMP1/TMRCMP2 on IDLE->RUN and at every wrap event.
  - Register changes mid-period take effect only at the next period boundary, so no glitched periods occur.
- Not defined:
  - pre_e=PRE, top_e=TMRCMP1 and duty_e=TMRCMP2 directly (live). No shadow flops are present.
  - Changes take effect on the next cycle.

Test Plan:
- Reset: assert PRESET 2 cycles with TMREN=1 -> all outputs 0. running=1 on the first edge after PRESET deasserts.
- Basic waveform: PRE=1, TMRCMP1=3, TMRCMP2=2, TMREN=1 -> tick every 2 cycles, period 8 cycles, pwm_out high 4 / low 4. period_tick pulses every 8 cycles; first pulse 9 cycles after running rises.
- Extremes: PRE=0, TMRCMP1=0, TMRCMP2=0 -> pwm_out constant 0 and period_tick every cycle. Then TMRCMP2=5 -> pwm_out constant 1.
- Disable mid-period: with the basic config, drop TMREN at cnt_val=2 -> next cycle running=0, cnt_val=0, pwm_out=0, no period_tick.
- Shadow update, with PWM32_SHADOW_EN: with the basic config, write TMRCMP2=4 at cnt_val=1 -> current period keeps 4-cycle high. Next period is 8 cycles fully high (duty>top). Without the macro, the change applies in the current period.
- TMREN drop exactly on a wrap cycle -> no period_tick, IDLE next cycle.
